write_ptr_block: RTL and testbench
==================================

// Module: write_ptr_block
// PURPOSE
//  Write-domain pointer and full-flag logic for the async FIFO; companion of the read-side pointer block.
//  Takes the read-domain gray pointer raw, synchronizes it into w_clk, and advances the binary/gray write pointers.
//  Drives the memory write address/strobe, the full flag, a fill-level estimate and a sticky overflow error.
// PARAMETERS
//  WDTH        3  address width; FIFO depth = 2**WDTH; pointers are WDTH+1 bits; WDTH >= 2
//  SYNC_STAGES 2  flops in read-pointer synchronizer chain; >= 2
//  AF_THRESH   2  almost-full margin in entries (used only with macro); 1..2**WDTH-1
// PORTS
//  w_clk         in   1       write-domain clock
//  w_reset       in   1       synchronous, active-high reset
//  w_enbl        in   1       write request from producer
//  read_ptr_gry  in   WDTH+1  read pointer, gray code, from r_clk domain (unsynchronized)
//  w_push        out  1       memory write strobe = w_enbl & ~full_flag (combinational)
//  w_addr        out  WDTH    memory write address = bin_wr_ptr[WDTH-1:0]
//  bin_wr_ptr    out  WDTH+1  binary write pointer (registered)
//  gry_wr_ptr    out  WDTH+1  gray write pointer (registered), sent to read domain
//  full_flag     out  1       FIFO full (registered)
//  wr_count      out  WDTH+1  fill estimate, 0..2**WDTH (registered)
//  overflow      out  1       sticky: write attempted while full
//  almost_full   out  1       see CONFIGURATION
// BEHAVIOUR
//  - Reset (w_reset high at posedge w_clk): bin_wr_ptr, gry_wr_ptr, every sync flop, wr_count = 0;
//    full_flag = 0, overflow = 0, almost_full = 0. Reset mid-operation discards all state on that edge;
//    both FIFO domains must be reset together (system rule, not checked here).
//  - Sync: read_ptr_gry -> SYNC_STAGES flop chain -> rd_sync; rd_bin = gray-to-binary(rd_sync).
//  - Next state: bin_nxt = bin_wr_ptr + w_push (mod 2**(WDTH+1)); gry_nxt = (bin_nxt >> 1) ^ bin_nxt.
//  - Each edge: bin_wr_ptr <= bin_nxt; gry_wr_ptr <= gry_nxt; write lands at w_addr on the same edge.
//  - Full: full_flag <= (gry_nxt == {~rd_sync[WDTH:WDTH-1], rd_sync[WDTH-2:0]}).
//    Asserts on the same edge as the write that fills the last entry (zero-lag).
//  - Full release is pessimistic: deasserts SYNC_STAGES+1 w_clk edges after read_ptr_gry advances.
//  - While full_flag = 1: w_push = 0; pointers hold.
//  - Registered count: wr_count <= bin_nxt - rd_bin (mod 2**(WDTH+1)); never exceeds 2**WDTH.
//  - Overflow: overflow <= overflow | (w_enbl & full_flag); cleared only by reset.
//  - Wrap: pointer rolls over from 2**(WDTH+1)-1 to 0; gray changes exactly one bit per increment.
//  - Same-edge write and read-pointer change: full is computed from the pre-edge rd_sync. The new read
//    value is seen only after the sync latency, so full is never falsely clear.
// CONFIGURATION
//  Macro WRITE_PTR_ALMOST_FULL_EN:
//   defined     almost_full <= (bin_nxt - rd_bin) >= 2**WDTH - AF_THRESH; registered; reset 0.
//   not defined almost_full tied to 1'b0; no comparator logic is generated.
// TESTING (WDTH=3, SYNC_STAGES=2)
//  1 Reset: w_reset=1 for 2 edges, w_enbl=1 -> all outputs 0; w_push=0 is not required (full=0, so w_push=1), but pointers stay 0 while in reset.
//  2 Fill: read_ptr_gry=0, w_enbl=1 for 8 edges -> w_addr 0..7; after 8th edge bin=8, gry=4'b1100,
//    full_flag=1, wr_count=8; 9th request -> w_push=0, pointers hold, overflow=1.
//  3 Release: from full, read_ptr_gry=4'b0001 -> full_flag stays 1 for 2 edges, clears on 3rd; wr_count=7.
//  4 Wrap: stream 20 writes, read_ptr_gry tracking 2 entries behind -> bin 15->0, gry 4'b1000->4'b0000,
//    full never set, overflow=0.
//  5 Mid-op reset: 5 writes, then w_reset=1 one edge -> bin=0, gry=0, wr_count=0, overflow cleared.
//  6 Macro on, AF_THRESH=2: 6 writes with read_ptr_gry=0 -> almost_full=1 after 6th edge (0 after 5th);
//    macro off -> almost_full=0 throughout.

Source files
------------

// File: rtl/write_ptr_block.sv
// Write-side pointer/full logic of the async FIFO: synchronizes the read gray pointer into w_clk
// and tracks the write pointers. Optional almost-full output is built only with WRITE_PTR_ALMOST_FULL_EN.
module write_ptr_block #(
  parameter int WDTH        = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 2
) (
  input  logic            w_clk,
  input  logic            w_reset,
  input  logic            w_enbl,
  input  logic [WDTH:0]   read_ptr_gry,
  output logic            w_push,
  output logic [WDTH-1:0] w_addr,
  output logic [WDTH:0]   bin_wr_ptr,
  output logic [WDTH:0]   gry_wr_ptr,
  output logic            full_flag,
  output logic [WDTH:0]   wr_count,
  output logic            overflow,
  output logic            almost_full
);

  localparam int PW = WDTH + 1;

  // Elaboration-time guards on the configuration space.
  if (WDTH < 2) begin : g_bad_wdth
    $error("write_ptr_block: WDTH must be >= 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("write_ptr_block: SYNC_STAGES must be >= 2");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > (2**WDTH) - 1)) begin : g_bad_af
    $error("write_ptr_block: AF_THRESH must be in 1..2**WDTH-1");
  end

  function automatic logic [WDTH:0] bin_to_gry(input logic [WDTH:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [WDTH:0] gry_to_bin(input logic [WDTH:0] g);
    logic [WDTH:0] b;
    b[WDTH] = g[WDTH];
    for (int i = WDTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Gray pattern of the write pointer when it sits exactly one lap ahead of the read pointer.
  function automatic logic [WDTH:0] full_pattern(input logic [WDTH:0] rg);
    return {~rg[WDTH:WDTH-1], rg[WDTH-2:0]};
  endfunction

  // Stage p0..pN: read pointer synchronizer chain into w_clk.
  logic [WDTH:0] rd_sync_p [SYNC_STAGES];
  logic [WDTH:0] rd_sync;
  logic [WDTH:0] rd_bin;

  always_ff @(posedge w_clk) begin
    if (w_reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        rd_sync_p[i] <= '0;
      end
    end else begin
      rd_sync_p[0] <= read_ptr_gry;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        rd_sync_p[i] <= rd_sync_p[i-1];
      end
    end
  end

  assign rd_sync = rd_sync_p[SYNC_STAGES-1];
  assign rd_bin  = gry_to_bin(rd_sync);

  logic [WDTH:0] bin_nxt;
  logic [WDTH:0] gry_nxt;
  logic [WDTH:0] count_nxt;
  logic          full_nxt;

  assign w_push    = w_enbl & ~full_flag;
  assign w_addr    = bin_wr_ptr[WDTH-1:0];
  assign bin_nxt   = bin_wr_ptr + PW'(w_push);
  assign gry_nxt   = bin_to_gry(bin_nxt);
  assign count_nxt = bin_nxt - rd_bin;
  assign full_nxt  = (gry_nxt == full_pattern(rd_sync));

  // Registered pointer / status stage.
  always_ff @(posedge w_clk) begin
    if (w_reset) begin
      bin_wr_ptr <= '0;
      gry_wr_ptr <= '0;
      full_flag  <= 1'b0;
      wr_count   <= '0;
      overflow   <= 1'b0;
    end else begin
      bin_wr_ptr <= bin_nxt;
      gry_wr_ptr <= gry_nxt;
      full_flag  <= full_nxt;
      wr_count   <= count_nxt;
      overflow   <= overflow | (w_enbl & full_flag);
    end
  end

`ifdef WRITE_PTR_ALMOST_FULL_EN
  localparam logic [WDTH:0] AF_LEVEL = PW'((2**WDTH) - AF_THRESH);

  always_ff @(posedge w_clk) begin
    if (w_reset) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= (count_nxt >= AF_LEVEL);
    end
  end
`else
  assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_write_ptr_block.sv
// Directed bench for write_ptr_block (WDTH=3, SYNC_STAGES=2, AF_THRESH=2).
module tb_write_ptr_block;

  localparam int WDTH = 3;

  logic            w_clk;
  logic            w_reset;
  logic            w_enbl;
  logic [WDTH:0]   read_ptr_gry;
  logic            w_push;
  logic [WDTH-1:0] w_addr;
  logic [WDTH:0]   bin_wr_ptr;
  logic [WDTH:0]   gry_wr_ptr;
  logic            full_flag;
  logic [WDTH:0]   wr_count;
  logic            overflow;
  logic            almost_full;

  int checks = 0;
  int errors = 0;

  write_ptr_block #(.WDTH(WDTH), .SYNC_STAGES(2), .AF_THRESH(2)) dut (
    .w_clk       (w_clk),
    .w_reset     (w_reset),
    .w_enbl      (w_enbl),
    .read_ptr_gry(read_ptr_gry),
    .w_push      (w_push),
    .w_addr      (w_addr),
    .bin_wr_ptr  (bin_wr_ptr),
    .gry_wr_ptr  (gry_wr_ptr),
    .full_flag   (full_flag),
    .wr_count    (wr_count),
    .overflow    (overflow),
    .almost_full (almost_full)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  function automatic logic [WDTH:0] gray(input logic [WDTH:0] b);
    return (b >> 1) ^ b;
  endfunction

  initial begin
    int n;
    logic [WDTH:0] rd;
    logic af_exp;

    // Reset held for two edges with a write request present.
    w_reset = 1'b1; w_enbl = 1'b1; read_ptr_gry = '0;
    tick(); tick();
    chk("rst_bin", 32'(bin_wr_ptr), 32'd0);
    chk("rst_gry", 32'(gry_wr_ptr), 32'd0);
    chk("rst_full", 32'(full_flag), 32'd0);
    chk("rst_cnt", 32'(wr_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_push", 32'(w_push), 32'd1);

    // Fill eight entries.
    w_reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge w_clk);
      chk("fill_addr", 32'(w_addr), 32'(i));
      chk("fill_push", 32'(w_push), 32'd1);
      tick();
    end
    chk("fill_bin", 32'(bin_wr_ptr), 32'd8);
    chk("fill_gry", 32'(gry_wr_ptr), 32'b1100);
    chk("fill_full", 32'(full_flag), 32'd1);
    chk("fill_cnt", 32'(wr_count), 32'd8);
    chk("fill_ovf0", 32'(overflow), 32'd0);
    @(negedge w_clk);
    chk("full_push", 32'(w_push), 32'd0);
    tick();
    chk("full_hold", 32'(bin_wr_ptr), 32'd8);
    chk("ovf_set", 32'(overflow), 32'd1);

    // One read seen by the read domain: release after sync latency.
    w_enbl = 1'b0; read_ptr_gry = 4'b0001;
    tick();
    chk("rel_e1", 32'(full_flag), 32'd1);
    tick();
    chk("rel_e2", 32'(full_flag), 32'd1);
    tick();
    chk("rel_e3", 32'(full_flag), 32'd0);
    chk("rel_cnt", 32'(wr_count), 32'd7);
    chk("rel_ovf", 32'(overflow), 32'd1);

    // Reset from a non-idle state clears everything, including overflow.
    w_reset = 1'b1;
    tick();
    w_reset = 1'b0; read_ptr_gry = '0;
    chk("mrst_bin", 32'(bin_wr_ptr), 32'd0);
    chk("mrst_gry", 32'(gry_wr_ptr), 32'd0);
    chk("mrst_cnt", 32'(wr_count), 32'd0);
    chk("mrst_ovf", 32'(overflow), 32'd0);
    chk("mrst_full", 32'(full_flag), 32'd0);

    // Stream 20 writes with the reader two entries behind: pointer wraps.
    w_enbl = 1'b1; n = 0;
    for (int i = 0; i < 20; i++) begin
      rd = (n >= 2) ? 4'(n - 2) : 4'd0;
      read_ptr_gry = gray(rd);
      tick();
      n++;
      chk("wrap_bin", 32'(bin_wr_ptr), 32'(n % 16));
      chk("wrap_gry", 32'(gry_wr_ptr), 32'(gray(4'(n % 16))));
      chk("wrap_full", 32'(full_flag), 32'd0);
      if (n == 15) chk("wrap_g15", 32'(gry_wr_ptr), 32'b1000);
      if (n == 16) chk("wrap_g0", 32'(gry_wr_ptr), 32'b0000);
    end
    chk("wrap_ovf", 32'(overflow), 32'd0);

    // Five writes from clean state, then a single reset edge.
    w_enbl = 1'b0; read_ptr_gry = '0; w_reset = 1'b1;
    tick();
    w_reset = 1'b0; w_enbl = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("five_bin", 32'(bin_wr_ptr), 32'd5);
    chk("five_cnt", 32'(wr_count), 32'd5);
    w_reset = 1'b1;
    tick();
    chk("r5_bin", 32'(bin_wr_ptr), 32'd0);
    chk("r5_gry", 32'(gry_wr_ptr), 32'd0);
    chk("r5_cnt", 32'(wr_count), 32'd0);
    chk("r5_ovf", 32'(overflow), 32'd0);

    // Almost-full threshold at 6 entries (only when the feature is built).
    w_reset = 1'b0; w_enbl = 1'b1; read_ptr_gry = '0;
    for (int i = 0; i < 5; i++) tick();
    chk("af_5", 32'(almost_full), 32'd0);
    tick();
`ifdef WRITE_PTR_ALMOST_FULL_EN
    af_exp = 1'b1;
`else
    af_exp = 1'b0;
`endif
    chk("af_6", 32'(almost_full), 32'(af_exp));
    chk("af_cnt", 32'(wr_count), 32'd6);
    w_enbl = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
